// File: rtl/sample_walker_pkg.sv
// Shared raster types for the sample walker: coordinate words, triangle/box/sample
// arrays, subsample step codes and the walker FSM state encoding.
package sample_walker_pkg;

  localparam int SIGFIG  = 24;
  localparam int RADIX   = 10;
  localparam int VERTS   = 3;
  localparam int AXIS    = 3;
  localparam int COLORS  = 3;
  localparam int SAMPLES = 3;

  localparam logic [3:0] SUB_ONE     = 4'b1000;
  localparam logic [3:0] SUB_HALF    = 4'b0100;
  localparam logic [3:0] SUB_QUARTER = 4'b0010;
  localparam logic [3:0] SUB_EIGHTH  = 4'b0001;

  typedef logic [SIGFIG-1:0]        word_t;
  typedef logic signed [SIGFIG:0]   wide_t;
  typedef word_t [VERTS-1:0][AXIS-1:0] tri_t;
  typedef word_t [COLORS-1:0]          color_t;
  typedef word_t [1:0][1:0]            box_t;
  typedef word_t [SAMPLES-1:0][1:0]    samp_t;

  typedef enum logic {WAIT_STATE, TEST_STATE} state_t;

  localparam wide_t ONE_STEP = wide_t'(1 << RADIX);

  // Unrecognised codes fall back to a full-pixel step.
  function automatic wide_t step_decode(input logic [3:0] code);
    case (code)
      SUB_ONE:     return ONE_STEP;
      SUB_HALF:    return ONE_STEP >>> 1;
      SUB_QUARTER: return ONE_STEP >>> 2;
      SUB_EIGHTH:  return ONE_STEP >>> 3;
      default:     return ONE_STEP;
    endcase
  endfunction

  function automatic wide_t sext(input word_t w);
    return {w[SIGFIG-1], w};
  endfunction

endpackage

// File: rtl/sample_walker.sv
// Walks a triangle's bounding box on the subsample grid, emitting SAMPLES adjacent
// sample positions per cycle while holding upstream off with an active-low halt.
module sample_walker
  import sample_walker_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  tri_t                tri_R14S,
  input  color_t              color_R14U,
  input  box_t                box_R14S,
  input  logic                validTri_R14H,
  input  logic [3:0]          subSample_RnnnnU,
  output logic                halt_RnnnnL,
  output tri_t                tri_R16S,
  output color_t              color_R16U,
  output samp_t               sample_R16S,
  output logic [SAMPLES-1:0]  validSamp_R16H
);

  state_t state;
  wide_t  x_cur, y_cur, ll_x, ur_x, ur_y, step;
  logic   degen;
  tri_t   tri_lat;
  color_t color_lat;

  wide_t  in_step, in_mask, in_ll_x, in_ll_y, in_ur_x, in_ur_y;
  wide_t  acc, next_x, next_y;
  wide_t  lane_x [SAMPLES];
  logic [SAMPLES-1:0] lane_ok;
  logic   row_wrap, last;

  // One extra bit of headroom keeps x_cur + SAMPLES*S from wrapping near UR.
  always_comb begin
    in_step = step_decode(subSample_RnnnnU);
    in_mask = ~(in_step - wide_t'(1));
    in_ll_x = sext(box_R14S[0][0]) & in_mask;
    in_ll_y = sext(box_R14S[0][1]) & in_mask;
    in_ur_x = sext(box_R14S[1][0]);
    in_ur_y = sext(box_R14S[1][1]);

    lane_x  = '{default: '0};
    lane_ok = '0;
    acc     = x_cur;
    for (int k = 0; k < SAMPLES; k++) begin
      lane_x[k]  = acc;
      lane_ok[k] = (acc <= ur_x) && (y_cur <= ur_y);
      acc        = acc + step;
    end
    next_x   = acc;
    next_y   = y_cur + step;
    row_wrap = next_x > ur_x;
    last     = degen || (row_wrap && (next_y > ur_y));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= WAIT_STATE;
      x_cur          <= '0;
      y_cur          <= '0;
      ll_x           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      step           <= '0;
      degen          <= 1'b0;
      tri_lat        <= '0;
      color_lat      <= '0;
      halt_RnnnnL    <= 1'b1;
      tri_R16S       <= '0;
      color_R16U     <= '0;
      sample_R16S    <= '0;
      validSamp_R16H <= '0;
    end else begin
      case (state)
        WAIT_STATE: begin
          validSamp_R16H <= '0;
          if (validTri_R14H) begin
            tri_lat     <= tri_R14S;
            color_lat   <= color_R14U;
            step        <= in_step;
            ll_x        <= in_ll_x;
            ur_x        <= in_ur_x;
            ur_y        <= in_ur_y;
            x_cur       <= in_ll_x;
            y_cur       <= in_ll_y;
            degen       <= (in_ur_x < in_ll_x) || (in_ur_y < in_ll_y);
            halt_RnnnnL <= 1'b0;
            state       <= TEST_STATE;
          end
        end
        TEST_STATE: begin
          for (int k = 0; k < SAMPLES; k++) begin
            sample_R16S[k][0] <= lane_x[k][SIGFIG-1:0];
            sample_R16S[k][1] <= y_cur[SIGFIG-1:0];
          end
          validSamp_R16H <= lane_ok;
          tri_R16S       <= tri_lat;
          color_R16U     <= color_lat;
          if (last) begin
            halt_RnnnnL <= 1'b1;
            state       <= WAIT_STATE;
          end else if (row_wrap) begin
            x_cur <= ll_x;
            y_cur <= next_y;
          end else begin
            x_cur <= next_x;
          end
        end
        default: state <= WAIT_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_walker.sv
// Directed-vector bench for sample_walker: box walks, row tails, half step,
// degenerate boxes, mid-box reset and back-to-back triangles.
module tb_sample_walker;
  import sample_walker_pkg::*;

  logic               clk;
  logic               rst;
  tri_t               tri_R14S;
  color_t             color_R14U;
  box_t               box_R14S;
  logic               validTri_R14H;
  logic [3:0]         subSample_RnnnnU;
  logic               halt_RnnnnL;
  tri_t               tri_R16S;
  color_t             color_R16U;
  samp_t              sample_R16S;
  logic [SAMPLES-1:0] validSamp_R16H;

  int checks   = 0;
  int failures = 0;

  sample_walker dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .box_R14S         (box_R14S),
    .validTri_R14H    (validTri_R14H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .tri_R16S         (tri_R16S),
    .color_R16U       (color_R16U),
    .sample_R16S      (sample_R16S),
    .validSamp_R16H   (validSamp_R16H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tri_t mk_tri(input int tag);
    tri_t t;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        t[v][a] = word_t'(tag * 16 + v * 4 + a);
    return t;
  endfunction

  function automatic color_t mk_color(input int tag);
    color_t c;
    for (int i = 0; i < COLORS; i++) c[i] = word_t'(tag * 8 + i + 100);
    return c;
  endfunction

  function automatic samp_t mk_samp(input int x0, input int s, input int y);
    samp_t r;
    for (int k = 0; k < SAMPLES; k++) begin
      r[k][0] = word_t'(x0 + k * s);
      r[k][1] = word_t'(y);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] ss, input int tag);
    box_R14S[0][0]   = word_t'(llx);
    box_R14S[0][1]   = word_t'(lly);
    box_R14S[1][0]   = word_t'(urx);
    box_R14S[1][1]   = word_t'(ury);
    subSample_RnnnnU = ss;
    tri_R14S         = mk_tri(tag);
    color_R14U       = mk_color(tag);
    validTri_R14H    = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    validTri_R14H = 1'b0;
    tri_R14S = '0; color_R14U = '0; box_R14S = '0; subSample_RnnnnU = 4'b1000;
    tick(); tick();
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL reset_halt got=%b exp=1", halt_RnnnnL); end
    checks++; if (validSamp_R16H !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", validSamp_R16H); end
    checks++; if (tri_R16S !== '0) begin failures++; $display("FAIL reset_tri got=%h exp=0", tri_R16S); end
    checks++; if (color_R16U !== '0) begin failures++; $display("FAIL reset_color got=%h exp=0", color_R16U); end
    checks++; if (sample_R16S !== '0) begin failures++; $display("FAIL reset_samp got=%h exp=0", sample_R16S); end
    #4 rst = 1'b1;
    tick();
  endtask

  task automatic test_full_box();
    present(0, 0, 2048, 1024, 4'b1000, 1);
    tick();
    validTri_R14H = 1'b0;
    checks++; if (halt_RnnnnL !== 1'b0) begin failures++; $display("FAIL full_halt_fall got=%b exp=0", halt_RnnnnL); end
    checks++; if (validSamp_R16H !== 3'b000) begin failures++; $display("FAIL full_valid_early got=%b exp=000", validSamp_R16H); end
    tick();
    checks++; if (sample_R16S !== mk_samp(0, 1024, 0)) begin failures++; $display("FAIL full_row0 got=%h exp=%h", sample_R16S, mk_samp(0, 1024, 0)); end
    checks++; if (validSamp_R16H !== 3'b111) begin failures++; $display("FAIL full_row0_valid got=%b exp=111", validSamp_R16H); end
    checks++; if (halt_RnnnnL !== 1'b0) begin failures++; $display("FAIL full_halt_mid got=%b exp=0", halt_RnnnnL); end
    checks++; if (tri_R16S !== mk_tri(1)) begin failures++; $display("FAIL full_tri got=%h exp=%h", tri_R16S, mk_tri(1)); end
    tick();
    checks++; if (sample_R16S !== mk_samp(0, 1024, 1024)) begin failures++; $display("FAIL full_row1 got=%h exp=%h", sample_R16S, mk_samp(0, 1024, 1024)); end
    checks++; if (validSamp_R16H !== 3'b111) begin failures++; $display("FAIL full_row1_valid got=%b exp=111", validSamp_R16H); end
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL full_halt_rise got=%b exp=1", halt_RnnnnL); end
    tick();
    checks++; if (validSamp_R16H !== 3'b000) begin failures++; $display("FAIL full_idle_valid got=%b exp=000", validSamp_R16H); end
  endtask

  task automatic test_row_tail();
    present(0, 0, 4096, 0, 4'b1000, 2);
    tick();
    validTri_R14H = 1'b0;
    tick();
    checks++; if (sample_R16S !== mk_samp(0, 1024, 0)) begin failures++; $display("FAIL tail_set0 got=%h exp=%h", sample_R16S, mk_samp(0, 1024, 0)); end
    checks++; if (validSamp_R16H !== 3'b111) begin failures++; $display("FAIL tail_set0_valid got=%b exp=111", validSamp_R16H); end
    tick();
    checks++; if (sample_R16S !== mk_samp(3072, 1024, 0)) begin failures++; $display("FAIL tail_set1 got=%h exp=%h", sample_R16S, mk_samp(3072, 1024, 0)); end
    checks++; if (validSamp_R16H !== 3'b011) begin failures++; $display("FAIL tail_set1_valid got=%b exp=011", validSamp_R16H); end
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL tail_halt got=%b exp=1", halt_RnnnnL); end
    tick();
  endtask

  task automatic test_half_step();
    present(0, 0, 512, 0, 4'b0100, 3);
    tick();
    validTri_R14H = 1'b0;
    tick();
    checks++; if (sample_R16S !== mk_samp(0, 512, 0)) begin failures++; $display("FAIL half_samp got=%h exp=%h", sample_R16S, mk_samp(0, 512, 0)); end
    checks++; if (validSamp_R16H !== 3'b011) begin failures++; $display("FAIL half_valid got=%b exp=011", validSamp_R16H); end
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL half_halt got=%b exp=1", halt_RnnnnL); end
    tick();
  endtask

  task automatic test_degenerate();
    present(0, 0, -1024, 4096, 4'b1000, 4);
    tick();
    validTri_R14H = 1'b0;
    checks++; if (halt_RnnnnL !== 1'b0) begin failures++; $display("FAIL degen_halt_fall got=%b exp=0", halt_RnnnnL); end
    tick();
    checks++; if (validSamp_R16H !== 3'b000) begin failures++; $display("FAIL degen_valid got=%b exp=000", validSamp_R16H); end
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL degen_halt_rise got=%b exp=1", halt_RnnnnL); end
    tick();
    checks++; if (validSamp_R16H !== 3'b000) begin failures++; $display("FAIL degen_valid2 got=%b exp=000", validSamp_R16H); end
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL degen_halt2 got=%b exp=1", halt_RnnnnL); end
  endtask

  task automatic test_mid_reset();
    present(0, 0, 2048, 3072, 4'b1000, 5);
    tick();
    validTri_R14H = 1'b0;
    tick(); tick();
    checks++; if (sample_R16S !== mk_samp(0, 1024, 1024)) begin failures++; $display("FAIL mid_row1 got=%h exp=%h", sample_R16S, mk_samp(0, 1024, 1024)); end
    #2 rst = 1'b0;
    #1;
    checks++; if (validSamp_R16H !== 3'b000) begin failures++; $display("FAIL mid_async_valid got=%b exp=000", validSamp_R16H); end
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL mid_async_halt got=%b exp=1", halt_RnnnnL); end
    #1 rst = 1'b1;
    tick();
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL mid_post_halt got=%b exp=1", halt_RnnnnL); end
    present(1500, 2100, 3072, 2048, 4'b0110, 6);
    tick();
    validTri_R14H = 1'b0;
    tick();
    checks++; if (sample_R16S !== mk_samp(1024, 1024, 2048)) begin failures++; $display("FAIL mid_new_start got=%h exp=%h", sample_R16S, mk_samp(1024, 1024, 2048)); end
    checks++; if (validSamp_R16H !== 3'b111) begin failures++; $display("FAIL mid_new_valid got=%b exp=111", validSamp_R16H); end
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL mid_new_halt got=%b exp=1", halt_RnnnnL); end
    tick();
  endtask

  task automatic test_back_to_back();
    present(0, 0, 2048, 1024, 4'b1000, 7);
    tick();
    present(4096, 4096, 6144, 4096, 4'b1000, 8);
    tick();
    checks++; if (tri_R16S !== mk_tri(7)) begin failures++; $display("FAIL b2b_tri_a got=%h exp=%h", tri_R16S, mk_tri(7)); end
    checks++; if (halt_RnnnnL !== 1'b0) begin failures++; $display("FAIL b2b_halt_a got=%b exp=0", halt_RnnnnL); end
    tick();
    checks++; if (halt_RnnnnL !== 1'b1) begin failures++; $display("FAIL b2b_halt_gap got=%b exp=1", halt_RnnnnL); end
    tick();
    checks++; if (halt_RnnnnL !== 1'b0) begin failures++; $display("FAIL b2b_accept_b got=%b exp=0", halt_RnnnnL); end
    checks++; if (tri_R16S !== mk_tri(7)) begin failures++; $display("FAIL b2b_tri_hold got=%h exp=%h", tri_R16S, mk_tri(7)); end
    checks++; if (validSamp_R16H !== 3'b000) begin failures++; $display("FAIL b2b_gap_valid got=%b exp=000", validSamp_R16H); end
    validTri_R14H = 1'b0;
    tick();
    checks++; if (tri_R16S !== mk_tri(8)) begin failures++; $display("FAIL b2b_tri_b got=%h exp=%h", tri_R16S, mk_tri(8)); end
    checks++; if (color_R16U !== mk_color(8)) begin failures++; $display("FAIL b2b_color_b got=%h exp=%h", color_R16U, mk_color(8)); end
    checks++; if (sample_R16S !== mk_samp(4096, 1024, 4096)) begin failures++; $display("FAIL b2b_samp_b got=%h exp=%h", sample_R16S, mk_samp(4096, 1024, 4096)); end
    checks++; if (validSamp_R16H !== 3'b111) begin failures++; $display("FAIL b2b_valid_b got=%b exp=111", validSamp_R16H); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_box();
    test_row_tail();
    test_half_step();
    test_degenerate();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
